// File: rtl/wave_pdm_pkg.sv
// Shared constants for the phase-accumulator tone synth and its PDM output stage.
package wave_pdm_pkg;

  localparam logic [1:0] MODE_SAW = 2'd0;
  localparam logic [1:0] MODE_TRI = 2'd1;
  localparam logic [1:0] MODE_SQR = 2'd2;
  localparam logic [1:0] MODE_OFF = 2'd3;

endpackage : wave_pdm_pkg

// File: rtl/wave_pdm_synth_if.sv
// Control and sample bus of the tone synth: settings in, PCM/wrap/PDM out.
interface wave_pdm_synth_if #(
  parameter int WIDTH  = 16,
  parameter int STEP_W = 16
);

  logic              en;
  logic [STEP_W-1:0] step_in;
  logic [1:0]        mode_in;
  logic [1:0]        atten_in;
  logic [WIDTH-1:0]  pcm_out;
  logic              wrap_out;
  logic              pdm_out;

  modport master (
    output en, step_in, mode_in, atten_in,
    input  pcm_out, wrap_out, pdm_out
  );

  modport slave (
    input  en, step_in, mode_in, atten_in,
    output pcm_out, wrap_out, pdm_out
  );

endinterface : wave_pdm_synth_if

// File: rtl/pdm_modulator.sv
// First-order sigma-delta modulator: the carry of err + pcm is the output bit.
module pdm_modulator #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pcm,
  output logic             pdm_out
);

  logic [WIDTH-1:0] err_reg;
  logic [WIDTH:0]   sum_next;

  assign sum_next = {1'b0, err_reg} + {1'b0, pcm};

  always_ff @(posedge clk) begin
    if (reset) begin
      err_reg <= '0;
      pdm_out <= 1'b0;
    end else begin
      err_reg <= sum_next[WIDTH-1:0];
      pdm_out <= sum_next[WIDTH];
    end
  end

endmodule : pdm_modulator

// File: rtl/wave_pdm_synth.sv
// Phase-accumulator synth (saw/tri/square/off) with attenuation, registered PCM and PDM output.
module wave_pdm_synth
  import wave_pdm_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int ACC_W  = 24,
  parameter int STEP_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  wave_pdm_synth_if.slave   bus
);

  localparam logic [WIDTH-1:0] MID = {1'b1, {(WIDTH-1){1'b0}}};

  logic [ACC_W-1:0]  phase_reg;
  logic [STEP_W-1:0] step_reg;
  logic [1:0]        mode_reg;
  logic [1:0]        atten_reg;
  logic [WIDTH-1:0]  pcm_reg;
  logic              wrap_reg;

  logic [ACC_W:0]    sum_next;
  logic              reload_next;
  logic [WIDTH-1:0]  top;
  logic [WIDTH-1:0]  tri_lo;
  logic [WIDTH-1:0]  wave_next;
  logic [WIDTH-1:0]  att_next;

  assign sum_next = {1'b0, phase_reg} + (ACC_W + 1)'(step_reg);

  // Settings only change at a period boundary so a waveform never glitches mid-cycle;
  // a zero step would never reach that boundary, so it reloads every edge instead.
  assign reload_next = (bus.en && sum_next[ACC_W]) || (step_reg == '0);

  assign top    = phase_reg[ACC_W-1 -: WIDTH];
  assign tri_lo = {top[WIDTH-2:0], 1'b0};

  always_comb begin
    wave_next = MID;
    case (mode_reg)
      MODE_SAW: wave_next = top;
      MODE_TRI: wave_next = top[WIDTH-1] ? ~tri_lo : tri_lo;
      MODE_SQR: wave_next = top[WIDTH-1] ? {WIDTH{1'b1}} : '0;
      MODE_OFF: wave_next = MID;
      default:  wave_next = MID;
    endcase
  end

  // Shrink toward midscale: the offset term re-centres the shifted sample.
  assign att_next = (wave_next >> atten_reg) + (MID - (MID >> atten_reg));

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_reg <= '0;
      wrap_reg  <= 1'b0;
      pcm_reg   <= MID;
      step_reg  <= bus.step_in;
      mode_reg  <= bus.mode_in;
      atten_reg <= bus.atten_in;
    end else begin
      pcm_reg <= att_next;
      if (bus.en) begin
        phase_reg <= sum_next[ACC_W-1:0];
        wrap_reg  <= sum_next[ACC_W];
      end else begin
        wrap_reg  <= 1'b0;
      end
      if (reload_next) begin
        step_reg  <= bus.step_in;
        mode_reg  <= bus.mode_in;
        atten_reg <= bus.atten_in;
      end
    end
  end

  pdm_modulator #(
    .WIDTH (WIDTH)
  ) u_pdm (
    .clk     (clk),
    .reset   (reset),
    .pcm     (pcm_reg),
    .pdm_out (bus.pdm_out)
  );

  assign bus.pcm_out  = pcm_reg;
  assign bus.wrap_out = wrap_reg;

endmodule : wave_pdm_synth

// File: tb/tb_wave_pdm_synth.sv
// Scoreboarded bench for wave_pdm_synth at WIDTH=8, ACC_W=12, STEP_W=12.
module tb_wave_pdm_synth;

  typedef struct {
    int pcm;
    int wrap;
    int pdm;
  } exp_t;

  logic clk;
  logic reset;

  wave_pdm_synth_if #(.WIDTH(8), .STEP_W(12)) bus ();

  wave_pdm_synth #(
    .WIDTH  (8),
    .ACC_W  (12),
    .STEP_W (12)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   asrt_cnt = 0;
  int   fail_cnt = 0;
  exp_t sb_q[$];

  // reference model state (integer arithmetic)
  int m_phase, m_err, m_pcm, m_wrap, m_pdm, m_step, m_mode, m_atten;
  int obs_pcm, obs_wrap, obs_pdm;

  task automatic check_val(input string tag, input int got, input int exp);
    asrt_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wave_model(input int phase, input int mode, input int atten);
    int t, w, d;
    t = phase / 16;
    case (mode)
      0:       w = t;
      1:       w = (t < 128) ? 2 * t : 255 - 2 * (t - 128);
      2:       w = (t >= 128) ? 255 : 0;
      default: w = 128;
    endcase
    d = 1 << atten;
    return w / d + 128 - 128 / d;
  endfunction

  task automatic model_step();
    int nxt, s, sum, carry;
    if (reset) begin
      m_phase = 0; m_err = 0; m_pcm = 128; m_wrap = 0; m_pdm = 0;
      m_step = int'(bus.step_in); m_mode = int'(bus.mode_in); m_atten = int'(bus.atten_in);
    end else begin
      nxt   = wave_model(m_phase, m_mode, m_atten);
      s     = m_err + m_pcm;
      m_pdm = (s >= 256) ? 1 : 0;
      m_err = s % 256;
      carry = 0;
      if (bus.en) begin
        sum     = m_phase + m_step;
        carry   = (sum >= 4096) ? 1 : 0;
        m_phase = sum % 4096;
      end
      m_wrap = carry;
      if (carry == 1 || m_step == 0) begin
        m_step = int'(bus.step_in); m_mode = int'(bus.mode_in); m_atten = int'(bus.atten_in);
      end
      m_pcm = nxt;
    end
  endtask

  // One clock: predict, push, let the edge happen, then pop and compare at the negedge.
  task automatic tick();
    exp_t e;
    model_step();
    e.pcm = m_pcm; e.wrap = m_wrap; e.pdm = m_pdm;
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    obs_pcm  = int'(bus.pcm_out);
    obs_wrap = int'(bus.wrap_out);
    obs_pdm  = int'(bus.pdm_out);
    check_val("sb_pcm",  obs_pcm,  e.pcm);
    check_val("sb_wrap", obs_wrap, e.wrap);
    check_val("sb_pdm",  obs_pdm,  e.pdm);
  endtask

  task automatic do_reset(input int step, input int mode, input int atten);
    reset        = 1'b1;
    bus.en       = 1'b1;
    bus.step_in  = 12'(step);
    bus.mode_in  = 2'(mode);
    bus.atten_in = 2'(atten);
    tick();
    check_val("rst_pcm",  obs_pcm,  128);
    check_val("rst_wrap", obs_wrap, 0);
    check_val("rst_pdm",  obs_pdm,  0);
    reset = 1'b0;
  endtask

  task automatic run_until_pcm(input int target, input string tag);
    int found;
    found = 0;
    for (int i = 0; i < 600 && found == 0; i++) begin
      tick();
      if (obs_pcm == target) found = 1;
    end
    check_val(tag, found, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ones, wraps, lo, hi, ev;

    // 1: OFF -> midscale, PDM at half density
    do_reset(16, 3, 0);
    ones = 0;
    repeat (256) begin tick(); ones += obs_pdm; end
    check_val("off_ones", ones, 128);
    check_val("off_pcm", obs_pcm, 128);

    // 2: sawtooth ramp and one wrap per period
    do_reset(16, 0, 0);
    wraps = 0;
    for (int k = 0; k < 256; k++) begin
      tick();
      check_val("saw_ramp", obs_pcm, k);
      wraps += obs_wrap;
    end
    check_val("saw_wraps", wraps, 1);
    tick();
    check_val("saw_after_wrap", obs_pcm, 0);

    // 3: triangle
    do_reset(16, 1, 0);
    for (int k = 0; k < 256; k++) begin
      tick();
      ev = (k < 128) ? 2 * k : 255 - 2 * (k - 128);
      check_val("tri", obs_pcm, ev);
    end
    tick();
    check_val("tri_after_wrap", obs_pcm, 0);

    // 4: mode change mid-period waits for the wrap
    do_reset(16, 0, 0);
    run_until_pcm(100, "saw_reach_100");
    bus.mode_in = 2'd2;
    for (int v = 101; v < 256; v++) begin tick(); check_val("saw_to_sqr_ramp", obs_pcm, v); end
    repeat (128) begin tick(); check_val("sqr_low", obs_pcm, 0); end
    repeat (128) begin tick(); check_val("sqr_high", obs_pcm, 255); end

    // 5: attenuated square levels
    do_reset(16, 2, 2);
    lo = 0; hi = 0;
    repeat (256) begin tick(); lo += (obs_pcm == 'h60) ? 1 : 0; hi += (obs_pcm == 'h9F) ? 1 : 0; end
    check_val("att2_lo", lo, 128);
    check_val("att2_hi", hi, 128);
    do_reset(16, 2, 3);
    lo = 0; hi = 0;
    repeat (256) begin tick(); lo += (obs_pcm == 'h70) ? 1 : 0; hi += (obs_pcm == 'h8F) ? 1 : 0; end
    check_val("att3_lo", lo, 128);
    check_val("att3_hi", hi, 128);

    // 6a: freeze at 0xC0, PDM density 3/4
    do_reset(16, 0, 0);
    run_until_pcm('hBF, "saw_reach_bf");
    bus.en = 1'b0;
    tick();
    check_val("hold_pcm", obs_pcm, 'hC0);
    repeat (4) tick();
    ones = 0; wraps = 0;
    repeat (256) begin tick(); ones += obs_pdm; wraps += obs_wrap; end
    check_val("hold_ones", ones, 192);
    check_val("hold_wraps", wraps, 0);
    check_val("hold_pcm_end", obs_pcm, 'hC0);

    // 6b: zero step reloads on the next edge
    do_reset(0, 0, 0);
    repeat (3) begin tick(); check_val("zero_step_pcm", obs_pcm, 0); end
    bus.step_in = 12'd16;
    tick(); check_val("reload_e1", obs_pcm, 0);
    tick(); check_val("reload_e2", obs_pcm, 0);
    tick(); check_val("reload_e3", obs_pcm, 1);

    // 6c: reset mid-ramp
    repeat (50) tick();
    reset = 1'b1;
    tick();
    check_val("midrst_pcm",  obs_pcm,  128);
    check_val("midrst_wrap", obs_wrap, 0);
    check_val("midrst_pdm",  obs_pdm,  0);
    reset = 1'b0;
    tick();
    check_val("post_rst_pcm", obs_pcm, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", asrt_cnt, fail_cnt);
    $finish;
  end

endmodule : tb_wave_pdm_synth
